serial_compare_sequencer: RTL

SERIAL_COMPARE_SEQUENCER -- requirements
Module: serial_compare_sequencer

---
 rtl/serial_compare_pkg.sv | 30 +++
 rtl/serial_msb_first_cmp_core.sv | 37 +++
 rtl/serial_compare_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_compare_pkg.sv
// Shared types for the serial MSB-first comparator: sequencer states, core states, result flags.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

    function automatic cmp_result_t cmp_decode(input cmp_state_t s);
        cmp_result_t r;
        r.less    = (s == CMP_LT);
        r.eq      = (s == CMP_EQ);
        r.greater = (s == CMP_GT);
        return r;
    endfunction

endpackage

// File: rtl/serial_msb_first_cmp_core.sv
// Bit-serial MSB-first magnitude comparator; o_result is combinational on the current bit pair.
// The first differing bit decides; later bits are ignored once a verdict is latched.
module serial_msb_first_cmp_core
    import serial_compare_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_a_bit,
    input  logic        i_b_bit,
    output cmp_result_t o_result
);

    cmp_state_t r_state;
    cmp_state_t w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == CMP_EQ && i_a_bit != i_b_bit) begin
            w_next = i_a_bit ? CMP_GT : CMP_LT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CMP_EQ;
        end else if (i_clr) begin
            r_state <= CMP_EQ;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_result = cmp_decode(w_next);

endmodule

// File: rtl/serial_compare_sequencer.sv
// Valid/ready wrapper that feeds operands MSB-first into the serial core; WIDTH+2 cycles per compare.
// Optional macro SERIAL_COMPARE_SEQUENCER_EARLY_EXIT_EN ends the shift on the first differing bit.
module serial_compare_sequencer
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_less,
    output logic             down_eq,
    output logic             down_greater
);

    localparam int CNT_W = $clog2(WIDTH);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    cmp_result_t      r_result;
    cmp_result_t      w_core_result;
    logic             w_accept;
    logic             w_shift_en;
    logic             w_finish;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        up_ready     = 1'b0;
        down_valid   = 1'b0;
        w_accept     = 1'b0;
        w_shift_en   = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
`ifdef SERIAL_COMPARE_SEQUENCER_EARLY_EXIT_EN
                if (r_cnt == '0 || !w_core_result.eq) begin
`else
                if (r_cnt == '0) begin
`endif
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                down_valid = 1'b1;
                if (down_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a   <= up_a;
            r_b   <= up_b;
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (w_shift_en) begin
            r_a <= r_a << 1;
            r_b <= r_b << 1;
            if (w_finish) begin
                r_result <= w_core_result;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    serial_msb_first_cmp_core u_core (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_accept),
        .i_en     (w_shift_en),
        .i_a_bit  (r_a[WIDTH-1]),
        .i_b_bit  (r_b[WIDTH-1]),
        .o_result (w_core_result)
    );

    // Flags are gated so they read all-zero whenever no result is offered.
    assign down_less    = down_valid & r_result.less;
    assign down_eq      = down_valid & r_result.eq;
    assign down_greater = down_valid & r_result.greater;

endmodule
